regfile_multiport_sb: RTL and testbench

Parametrised successor to the single-issue integer register file. It provides NREAD combinational read ports and one write port. The write path does sub-word size selection and zero/sign extension. A per-register pending scoreboard tracks in-flight producers for hazard detection in the issue stage. A sequential clear engine zeroes the array after reset so the array can map onto RAM.

---
 rtl/regfile_multiport_sb_if.sv | 29 ++
 rtl/regfile_multiport_sb.sv | 60 ++++++
 tb/tb_regfile_multiport_sb.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_multiport_sb_if.sv
// regfile_multiport_sb_if: write, read, issue and scoreboard signals of the multiport register file
// master drives write/read indices/issue/flush; slave returns ready, read data and pending flags.
interface regfile_multiport_sb_if #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);
  logic ready;
  logic write;
  logic [1:0] writeSize;
  logic writeExtend;
  logic [AW-1:0] rd;
  logic [XLEN-1:0] writeData;
  logic [NREAD*AW-1:0] rs;
  logic [NREAD*XLEN-1:0] registerData;
  logic issueValid;
  logic [AW-1:0] issueRd;
  logic flush;
  logic [NREAD-1:0] rsPending;
  modport master (
    input ready, registerData, rsPending,
    output write, writeSize, writeExtend, rd, writeData, rs, issueValid, issueRd, flush
  );
  modport slave (
    output ready, registerData, rsPending,
    input write, writeSize, writeExtend, rd, writeData, rs, issueValid, issueRd, flush
  );
endinterface

// File: rtl/regfile_multiport_sb.sv
// regfile_multiport_sb: NREAD-read/1-write register file with sub-word extension, pending scoreboard and post-reset clear sweep
// clk/reset: clock and synchronous active-high reset; bus: write port, packed read ports,
// issue/flush scoreboard inputs, ready and per-port pending outputs.
module regfile_multiport_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic reset,
  regfile_multiport_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  typedef enum logic {CLEAR, RUN} stateT;
  stateT state;
  logic [AW-1:0] cnt;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pending, pendNext;
  logic [XLEN-1:0] ext;
  logic run, wen;
  assign run = state == RUN;
  assign wen = run && bus.write && bus.rd != '0;
  assign bus.ready = run;
  assign ext = bus.writeSize == 2'b00 ? XLEN'(bus.writeData[0]) :
               bus.writeSize == 2'b01 ? {{(XLEN-8){bus.writeExtend & bus.writeData[7]}}, bus.writeData[7:0]} :
               bus.writeSize == 2'b10 ? {{(XLEN-16){bus.writeExtend & bus.writeData[15]}}, bus.writeData[15:0]} :
               bus.writeData;
  // A new producer issued this cycle outranks the write retiring the previous one.
  always_comb begin
    pendNext = pending;
    for (int r = 0; r < NREGS; r++)
      pendNext[r] = r == 0 || bus.flush ? 1'b0 :
                    bus.issueValid && bus.issueRd == AW'(r) ? 1'b1 :
                    bus.write && bus.rd == AW'(r) ? 1'b0 : pending[r];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt <= AW'(1);
      pending <= '0;
    end else if (!run) begin
      cnt <= cnt + 1'b1;
      if (cnt == AW'(NREGS - 1)) state <= RUN;
    end else begin
      pending <= pendNext;
    end
  end
  // Reset-free single write port so the array can map onto RAM; the sweep zeroes it instead.
  always_ff @(posedge clk)
    if (!reset && (!run || wen)) regs[run ? bus.rd : cnt] <= run ? ext : '0;
  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0] idx;
    logic hit;
    assign idx = bus.rs[i*AW +: AW];
    assign hit = BYPASS != 0 && bus.write && bus.rd == idx;
    assign bus.registerData[i*XLEN +: XLEN] = !run || idx == '0 ? '0 : hit ? ext : regs[idx];
    assign bus.rsPending[i] = run && pending[idx] && !(hit && !(bus.issueValid && bus.issueRd == idx));
  end
endmodule

// File: tb/tb_regfile_multiport_sb.sv
// tb_regfile_multiport_sb: randomized and directed checks of regfile_multiport_sb (BYPASS 1 and 0) against a behavioural model
module tb_regfile_multiport_sb;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 3;
  logic clk = 0;
  logic reset = 1;
  int asserts = 0;
  int failures = 0;
  logic [31:0] mem [32];
  bit pend [32];
  int sweepLeft = 0;
  logic [1:0] szT [7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3};
  logic sxT [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] expT [7] = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_80F1, 32'h0000_80F1,
                            32'h0000_0001, 32'h1234_80F1, 32'h1234_80F1};
  always #5 clk = ~clk;
  regfile_multiport_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) busA ();
  regfile_multiport_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) busB ();
  assign busB.write = busA.write;
  assign busB.writeSize = busA.writeSize;
  assign busB.writeExtend = busA.writeExtend;
  assign busB.rd = busA.rd;
  assign busB.writeData = busA.writeData;
  assign busB.rs = busA.rs;
  assign busB.issueValid = busA.issueValid;
  assign busB.issueRd = busA.issueRd;
  assign busB.flush = busA.flush;
  regfile_multiport_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dutA (
    .clk(clk), .reset(reset), .bus(busA.slave));
  regfile_multiport_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dutB (
    .clk(clk), .reset(reset), .bus(busB.slave));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    asserts++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] extOf(input logic [1:0] s, input logic sx, input logic [31:0] d);
    case (s)
      2'd0: return d % 2;
      2'd1: return (sx && d % 256 >= 128) ? d % 256 + 32'hFFFF_FF00 : d % 256;
      2'd2: return (sx && d % 65536 >= 32768) ? d % 65536 + 32'hFFFF_0000 : d % 65536;
      default: return d;
    endcase
  endfunction
  function automatic logic [31:0] readExp(input bit byp, input logic [4:0] idx);
    if (sweepLeft != 0 || idx == 0) return 0;
    if (byp && busA.write && busA.rd == idx) return extOf(busA.writeSize, busA.writeExtend, busA.writeData);
    return mem[idx];
  endfunction
  function automatic logic pendExp(input bit byp, input logic [4:0] idx);
    if (sweepLeft != 0 || !pend[idx]) return 0;
    return !(byp && busA.write && busA.rd == idx && !(busA.issueValid && busA.issueRd == idx));
  endfunction
  task automatic compareAll();
    logic [4:0] idx;
    check("readyA", busA.ready, sweepLeft == 0);
    check("readyB", busB.ready, sweepLeft == 0);
    for (int i = 0; i < NREAD; i++) begin
      idx = busA.rs[i*5 +: 5];
      check($sformatf("dataA[%0d]", i), busA.registerData[i*32 +: 32], readExp(1, idx));
      check($sformatf("dataB[%0d]", i), busB.registerData[i*32 +: 32], readExp(0, idx));
      check($sformatf("pendA[%0d]", i), busA.rsPending[i], pendExp(1, idx));
      check($sformatf("pendB[%0d]", i), busB.rsPending[i], pendExp(0, idx));
    end
  endtask
  task automatic modelEdge();
    if (reset) begin
      sweepLeft = NREGS - 1;
      foreach (mem[r]) mem[r] = 0;
      foreach (pend[r]) pend[r] = 0;
    end else if (sweepLeft > 0) begin
      sweepLeft--;
    end else begin
      if (busA.write && busA.rd != 0) mem[busA.rd] = extOf(busA.writeSize, busA.writeExtend, busA.writeData);
      if (busA.flush) begin
        foreach (pend[r]) pend[r] = 0;
      end else begin
        if (busA.write) pend[busA.rd] = 0;
        if (busA.issueValid && busA.issueRd != 0) pend[busA.issueRd] = 1;
      end
    end
  endtask
  task automatic tick();
    #3;
    compareAll();
    modelEdge();
    @(posedge clk);
    #1;
  endtask
  task automatic setIn(input logic w, input logic [1:0] sz, input logic sx, input logic [4:0] rdv,
                       input logic [31:0] d, input logic iv, input logic [4:0] ird, input logic fl,
                       input logic [14:0] rsv);
    busA.write = w;
    busA.writeSize = sz;
    busA.writeExtend = sx;
    busA.rd = rdv;
    busA.writeData = d;
    busA.issueValid = iv;
    busA.issueRd = ird;
    busA.flush = fl;
    busA.rs = rsv;
  endtask
  task automatic idle(input logic [14:0] rsv);
    setIn(0, 2'd3, 0, 0, 0, 0, 0, 0, rsv);
  endtask
  function automatic logic [14:0] rs3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {c, b, a};
  endfunction
  function automatic logic [4:0] pick();
    return $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
  endfunction
  task automatic sweepCount(input string tag);
    int n = 0;
    for (int k = 0; k < 100; k++) begin
      if (k == 3) setIn(1, 2'd3, 0, 5, 32'h5555_5555, 1, 5, 0, rs3(5, 5, 5));
      else idle(rs3(5, 5, 5));
      tick();
      n++;
      if (busA.ready) break;
    end
    check(tag, n, 31);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [4:0] rdv, ird;
    idle(0);
    modelEdge();
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 0;
    sweepCount("sweepLen");
    idle(rs3(5, 5, 5));
    #1;
    check("clearDrop", busA.registerData[31:0], 0);
    reset = 1;
    tick();
    reset = 0;
    repeat (10) tick();
    reset = 1;
    tick();
    reset = 0;
    sweepCount("resweepLen");
    for (int k = 0; k < 7; k++) begin
      setIn(1, szT[k], sxT[k], 7, 32'h1234_80F1, 0, 0, 0, rs3(0, 0, 0));
      tick();
      idle(rs3(7, 7, 7));
      #1;
      check($sformatf("extA%0d", k), busA.registerData[31:0], expT[k]);
      check($sformatf("extB%0d", k), busB.registerData[95:64], expT[k]);
    end
    setIn(1, 2'd3, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, rs3(0, 0, 0));
    #1;
    check("x0Bypass", busA.registerData, 0);
    tick();
    setIn(0, 2'd3, 0, 0, 0, 1, 0, 0, rs3(0, 0, 0));
    tick();
    idle(rs3(0, 0, 0));
    #1;
    check("x0Read", busA.registerData, 0);
    check("x0Pend", busA.rsPending, 0);
    setIn(1, 2'd3, 0, 3, 32'h1111_1111, 0, 0, 0, rs3(0, 0, 0));
    tick();
    setIn(1, 2'd3, 0, 3, 32'hCAFE_0001, 0, 0, 0, rs3(3, 3, 0));
    #1;
    check("bypA0", busA.registerData[31:0], 32'hCAFE_0001);
    check("bypA1", busA.registerData[63:32], 32'hCAFE_0001);
    check("noBypB0", busB.registerData[31:0], 32'h1111_1111);
    tick();
    idle(rs3(3, 3, 0));
    #1;
    check("afterB1", busB.registerData[63:32], 32'hCAFE_0001);
    setIn(0, 2'd3, 0, 0, 0, 1, 9, 0, rs3(0, 0, 0));
    tick();
    idle(rs3(9, 9, 9));
    #1;
    check("issue9A", busA.rsPending, 3'b111);
    setIn(1, 2'd3, 0, 9, 32'h99, 0, 0, 0, rs3(9, 9, 9));
    #1;
    check("maskA", busA.rsPending, 3'b000);
    check("noMaskB", busB.rsPending, 3'b111);
    tick();
    idle(rs3(9, 9, 9));
    #1;
    check("retire9", busB.rsPending, 3'b000);
    setIn(1, 2'd3, 0, 9, 32'h98, 1, 9, 0, rs3(9, 9, 9));
    #1;
    check("reissueA", busA.rsPending, 3'b000);
    tick();
    idle(rs3(9, 9, 9));
    #1;
    check("reissue9", busA.rsPending, 3'b111);
    setIn(0, 2'd3, 0, 0, 0, 1, 4, 0, rs3(4, 9, 4));
    tick();
    setIn(0, 2'd3, 0, 0, 0, 1, 4, 1, rs3(4, 9, 4));
    tick();
    idle(rs3(4, 9, 4));
    #1;
    check("flush4", busA.rsPending, 3'b000);
    for (int k = 0; k < 20000; k++) begin
      reset = $urandom_range(0, 1999) == 0;
      rdv = pick();
      ird = $urandom_range(0, 1) ? rdv : pick();
      setIn($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rdv, $urandom(),
            $urandom_range(0, 2) == 0, ird, $urandom_range(0, 15) == 0,
            rs3($urandom_range(0, 1) ? rdv : pick(), $urandom_range(0, 1) ? ird : pick(), pick()));
      tick();
    end
    reset = 0;
    idle(0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
